// File: rtl/clock_core_multi_alarm_if.sv
// Bundles the clock core's control, adjust, alarm-table and time/indicator
// signals so the core and its consumers share a single port.
interface clock_core_multi_alarm_if #(
  parameter int unsigned NUM_ALARMS = 4
);
  logic                  EN;
  logic                  Ctrl24To12;
  logic                  AdjH;
  logic                  AdjM;
  logic                  AlarmWr;
  logic [3:0]            AlarmSel;
  logic                  AlarmEnIn;
  logic [4:0]            AlarmHIn;
  logic [5:0]            AlarmMIn;
  logic                  AlarmAck;
  logic [4:0]            Hour;
  logic [5:0]            Min;
  logic [5:0]            Sec;
  logic [4:0]            DispHour;
  logic                  PM;
  logic                  SecTick;
  logic [NUM_ALARMS-1:0] AlarmHit;
  logic                  LEDAlarm;
  logic                  LEDZ;

  modport slave (
    input  EN, Ctrl24To12, AdjH, AdjM, AlarmWr, AlarmSel, AlarmEnIn,
           AlarmHIn, AlarmMIn, AlarmAck,
    output Hour, Min, Sec, DispHour, PM, SecTick, AlarmHit, LEDAlarm, LEDZ
  );

  modport master (
    output EN, Ctrl24To12, AdjH, AdjM, AlarmWr, AlarmSel, AlarmEnIn,
           AlarmHIn, AlarmMIn, AlarmAck,
    input  Hour, Min, Sec, DispHour, PM, SecTick, AlarmHit, LEDAlarm, LEDZ
  );
endinterface

// File: rtl/clock_core_multi_alarm.sv
// Time-of-day core: prescaler, H:M:S chain, 12/24 h mapping, hour/minute
// adjust, alarm table with ring timeout, and hourly chime.
module clock_core_multi_alarm #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned RING_SECS  = 30,
  parameter int unsigned CHIME_SECS = 5
) (
  input  logic                        CP50,
  input  logic                        CR,
  clock_core_multi_alarm_if.slave     bus
);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam int unsigned CW = $clog2(CHIME_SECS + 1);

  typedef struct packed {
    logic       en;
    logic [4:0] h;
    logic [5:0] m;
  } alarm_t;

  logic [PW-1:0]         presc_q, presc_d;
  logic                  tick_q, tick_d;
  logic [4:0]            hour_q, hour_d;
  logic [5:0]            min_q, min_d;
  logic [5:0]            sec_q, sec_d;
  logic                  adjh_hist_q, adjh_hist_d;
  logic                  adjm_hist_q, adjm_hist_d;
  logic [NUM_ALARMS-1:0] hit_q, hit_d;
  logic [RW-1:0]         ring_q, ring_d;
  logic [CW-1:0]         chime_q, chime_d;
  logic                  ledz_q, ledz_d;
  alarm_t                alarm_q [NUM_ALARMS];
  alarm_t                alarm_d [NUM_ALARMS];

  logic                  adjh_edge, adjm_edge, adj_any, tick_use;
  logic                  sec_wrap, min_wrap, wr_ok;
  logic [NUM_ALARMS-1:0] hit_new;
  logic [4:0]            disp_hour_c;
  logic                  pm_c;

  always_ff @(posedge CP50) begin
    if (CR) begin
      presc_q     <= '0;
      tick_q      <= 1'b0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      adjh_hist_q <= 1'b1;
      adjm_hist_q <= 1'b1;
      hit_q       <= '0;
      ring_q      <= '0;
      chime_q     <= '0;
      ledz_q      <= 1'b0;
      for (int i = 0; i < int'(NUM_ALARMS); i++) alarm_q[i] <= '0;
    end else begin
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      adjh_hist_q <= adjh_hist_d;
      adjm_hist_q <= adjm_hist_d;
      hit_q       <= hit_d;
      ring_q      <= ring_d;
      chime_q     <= chime_d;
      ledz_q      <= ledz_d;
      for (int i = 0; i < int'(NUM_ALARMS); i++) alarm_q[i] <= alarm_d[i];
    end
  end

  always_comb begin
    presc_d     = presc_q;
    tick_d      = 1'b0;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    hit_d       = hit_q;
    ring_d      = ring_q;
    chime_d     = chime_q;
    hit_new     = '0;
    for (int i = 0; i < int'(NUM_ALARMS); i++) alarm_d[i] = alarm_q[i];

    adjh_hist_d = bus.AdjH;
    adjm_hist_d = bus.AdjM;
    adjh_edge   = bus.AdjH & ~adjh_hist_q;
    adjm_edge   = bus.AdjM & ~adjm_hist_q;
    adj_any     = adjh_edge | adjm_edge;
    // An adjust edge swallows any coincident tick.
    tick_use    = tick_q & ~adj_any;
    sec_wrap    = tick_use && (sec_q == 6'd59);
    min_wrap    = sec_wrap && (min_q == 6'd59);

    if (bus.EN) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (adj_any) begin
      if (adjh_edge) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      if (adjm_edge) begin
        min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        sec_d = 6'd0;
      end
    end else if (tick_use) begin
      sec_d = sec_wrap ? 6'd0 : sec_q + 6'd1;
      if (sec_wrap) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      if (min_wrap) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
    end

    for (int i = 0; i < int'(NUM_ALARMS); i++) begin
      if (sec_wrap && alarm_q[i].en && (alarm_q[i].h == hour_d) &&
          (alarm_q[i].m == min_d))
        hit_new[i] = 1'b1;
    end

    if (tick_use && (|hit_q)) begin
      if (ring_q == RW'(RING_SECS - 1)) begin
        hit_d  = '0;
        ring_d = '0;
      end else begin
        ring_d = ring_q + RW'(1);
      end
    end
    if (bus.AlarmAck) begin
      hit_d  = '0;
      ring_d = '0;
    end

    wr_ok = bus.AlarmWr && (32'(bus.AlarmSel) < NUM_ALARMS) &&
            (bus.AlarmHIn <= 5'd23) && (bus.AlarmMIn <= 6'd59);
    for (int i = 0; i < int'(NUM_ALARMS); i++) begin
      if (wr_ok && (bus.AlarmSel == 4'(i))) begin
        alarm_d[i] = '{en: bus.AlarmEnIn, h: bus.AlarmHIn, m: bus.AlarmMIn};
        if (!bus.AlarmEnIn) hit_d[i] = 1'b0;
      end
    end

    // Fresh hits override ack/timeout and restart the ring window.
    if (|hit_new) ring_d = '0;
    hit_d = hit_d | hit_new;

    if (min_wrap) chime_d = CW'(CHIME_SECS);
    else if (tick_use && (chime_q != '0)) chime_d = chime_q - CW'(1);
    ledz_d = (chime_d != '0);
  end

  always_comb begin
    disp_hour_c = hour_q;
    if (bus.Ctrl24To12) begin
      if (hour_q == 5'd0)       disp_hour_c = 5'd12;
      else if (hour_q > 5'd12)  disp_hour_c = hour_q - 5'd12;
    end
    pm_c = (hour_q >= 5'd12);
  end

  assign bus.Hour     = hour_q;
  assign bus.Min      = min_q;
  assign bus.Sec      = sec_q;
  assign bus.DispHour = disp_hour_c;
  assign bus.PM       = pm_c;
  assign bus.SecTick  = tick_q;
  assign bus.AlarmHit = hit_q;
  assign bus.LEDAlarm = |hit_q;
  assign bus.LEDZ     = ledz_q;
endmodule

// File: tb/tb_clock_core_multi_alarm.sv
// Directed bench for clock_core_multi_alarm: display-mapping vector table
// plus hand sequences for rollover, adjust, alarm, ack race and chime.
module tb_clock_core_multi_alarm;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned NUM_ALARMS = 4;
  localparam int unsigned RING_SECS  = 3;
  localparam int unsigned CHIME_SECS = 5;

  logic CP50 = 1'b0;
  logic CR   = 1'b0;
  int   checks = 0;
  int   errors = 0;

  clock_core_multi_alarm_if #(.NUM_ALARMS(NUM_ALARMS)) bus ();

  clock_core_multi_alarm #(
    .TICK_DIV(TICK_DIV), .NUM_ALARMS(NUM_ALARMS),
    .RING_SECS(RING_SECS), .CHIME_SECS(CHIME_SECS)
  ) dut (
    .CP50(CP50),
    .CR  (CR),
    .bus (bus.slave)
  );

  always #5 CP50 = ~CP50;

  typedef struct {
    int   hour;
    logic ctrl;
    int   disp;
    int   pm;
  } disp_vec_t;

  disp_vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    CR = 1'b1;
    @(negedge CP50);
    @(negedge CP50);
    CR = 1'b0;
    @(negedge CP50);
  endtask

  task automatic pulse_h(input int n);
    repeat (n) begin
      bus.AdjH = 1'b1; @(negedge CP50);
      bus.AdjH = 1'b0; @(negedge CP50);
    end
  endtask

  task automatic pulse_m(input int n);
    repeat (n) begin
      bus.AdjM = 1'b1; @(negedge CP50);
      bus.AdjM = 1'b0; @(negedge CP50);
    end
  endtask

  task automatic write_alarm(input int sel, input logic en, input int h, input int m);
    bus.AlarmWr   = 1'b1;
    bus.AlarmSel  = 4'(sel);
    bus.AlarmEnIn = en;
    bus.AlarmHIn  = 5'(h);
    bus.AlarmMIn  = 6'(m);
    @(negedge CP50);
    bus.AlarmWr   = 1'b0;
  endtask

  // Returns on the negedge where SecTick is seen high (tick not yet applied).
  task automatic wait_tick_seen();
    int budget = 0;
    while (!bus.SecTick) begin
      @(negedge CP50);
      budget++;
      if (budget > 4 * int'(TICK_DIV) + 10) begin
        checks++; errors++;
        $display("FAIL tick_timeout: got no SecTick expected one");
        return;
      end
    end
  endtask

  // Returns once n ticks have been applied to the time registers.
  task automatic wait_ticks(input int n);
    int cnt = 0;
    int budget = 0;
    while (cnt < n) begin
      @(negedge CP50);
      if (bus.SecTick) cnt++;
      budget++;
      if (budget > n * 2 * int'(TICK_DIV) + 20) begin
        checks++; errors++;
        $display("FAIL ticks_timeout: got %0d ticks expected %0d", cnt, n);
        return;
      end
    end
    @(negedge CP50);
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s);
    check({name, "_hour"}, int'(bus.Hour), h);
    check({name, "_min"},  int'(bus.Min),  m);
    check({name, "_sec"},  int'(bus.Sec),  s);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{hour: 0,  ctrl: 1'b1, disp: 12, pm: 0};
    vecs[1] = '{hour: 11, ctrl: 1'b1, disp: 11, pm: 0};
    vecs[2] = '{hour: 12, ctrl: 1'b1, disp: 12, pm: 1};
    vecs[3] = '{hour: 13, ctrl: 1'b1, disp: 1,  pm: 1};
    vecs[4] = '{hour: 23, ctrl: 1'b1, disp: 11, pm: 1};
    vecs[5] = '{hour: 1,  ctrl: 1'b1, disp: 1,  pm: 0};
    vecs[6] = '{hour: 0,  ctrl: 1'b0, disp: 0,  pm: 0};
    vecs[7] = '{hour: 13, ctrl: 1'b0, disp: 13, pm: 1};

    bus.EN = 1'b0; bus.Ctrl24To12 = 1'b0; bus.AdjH = 1'b0; bus.AdjM = 1'b0;
    bus.AlarmWr = 1'b0; bus.AlarmSel = '0; bus.AlarmEnIn = 1'b0;
    bus.AlarmHIn = '0; bus.AlarmMIn = '0; bus.AlarmAck = 1'b0;
    @(negedge CP50);

    // Reset state
    bus.EN = 1'b1;
    do_reset();
    check_time("reset", 0, 0, 0);
    check("reset_hit",  int'(bus.AlarmHit), 0);
    check("reset_ledz", int'(bus.LEDZ), 0);

    // Tick period and 60-second rollover
    wait_tick_seen();
    @(negedge CP50);
    n = 1;
    while (!bus.SecTick && n < 50) begin @(negedge CP50); n++; end
    check("tick_period", n, int'(TICK_DIV));
    do_reset();
    wait_ticks(60);
    check_time("roll60", 0, 1, 0);

    // Day rollover from 23:59:59
    bus.EN = 1'b0;
    do_reset();
    pulse_h(23);
    pulse_m(59);
    bus.EN = 1'b1;
    wait_ticks(59);
    check_time("pre_day", 23, 59, 59);
    wait_ticks(1);
    check_time("day_roll", 0, 0, 0);
    check("day_roll_pm", int'(bus.PM), 0);
    check("day_roll_chime", int'(bus.LEDZ), 1);

    // Display mapping table
    for (int i = 0; i < 8; i++) begin
      bus.EN = 1'b0;
      do_reset();
      pulse_h(vecs[i].hour);
      bus.Ctrl24To12 = vecs[i].ctrl;
      @(negedge CP50);
      check($sformatf("map%0d_hour", i), int'(bus.Hour), vecs[i].hour);
      check($sformatf("map%0d_disp", i), int'(bus.DispHour), vecs[i].disp);
      check($sformatf("map%0d_pm", i),   int'(bus.PM), vecs[i].pm);
    end
    bus.Ctrl24To12 = 1'b0;

    // AdjM held for 10 cycles: one minute, seconds cleared
    bus.EN = 1'b1;
    do_reset();
    wait_ticks(5);
    bus.EN = 1'b0;
    bus.AdjM = 1'b1;
    repeat (10) @(negedge CP50);
    bus.AdjM = 1'b0;
    @(negedge CP50);
    check_time("adjm_hold", 0, 1, 0);

    // AdjH at 23 wraps with minute untouched, no chime
    do_reset();
    pulse_m(7);
    pulse_h(23);
    pulse_h(1);
    check_time("adjh_wrap", 0, 7, 0);
    check("adjh_no_chime", int'(bus.LEDZ), 0);

    // Simultaneous AdjH and AdjM
    bus.AdjH = 1'b1; bus.AdjM = 1'b1;
    @(negedge CP50);
    bus.AdjH = 1'b0; bus.AdjM = 1'b0;
    @(negedge CP50);
    check_time("adj_both", 1, 8, 0);

    // AdjM edge on the SecTick cycle discards the tick
    bus.EN = 1'b1;
    do_reset();
    wait_ticks(3);
    check("pre_adj_tick_sec", int'(bus.Sec), 3);
    wait_tick_seen();
    bus.AdjM = 1'b1;
    @(negedge CP50);
    bus.AdjM = 1'b0;
    check_time("adj_on_tick", 0, 1, 0);
    wait_ticks(1);
    check("after_adj_tick_sec", int'(bus.Sec), 1);

    // AdjH held through reset release does not fire
    bus.EN = 1'b0;
    bus.AdjH = 1'b1;
    do_reset();
    repeat (3) @(negedge CP50);
    check("adjh_through_reset", int'(bus.Hour), 0);
    bus.AdjH = 1'b0;
    @(negedge CP50);

    // Alarm table: entry 2 rings, disabled/out-of-range entries never do
    do_reset();
    write_alarm(2, 1'b1, 7, 30);
    write_alarm(3, 1'b0, 7, 30);
    write_alarm(5, 1'b1, 7, 30);
    pulse_h(7);
    pulse_m(29);
    bus.EN = 1'b1;
    wait_ticks(58);
    check_time("pre_alarm", 7, 29, 58);
    check("pre_alarm_hit", int'(bus.AlarmHit), 0);
    wait_ticks(2);
    check_time("alarm", 7, 30, 0);
    check("alarm_hit", int'(bus.AlarmHit), 4'b0100);
    check("alarm_led", int'(bus.LEDAlarm), 1);
    wait_ticks(2);
    check("ring_hold", int'(bus.AlarmHit), 4'b0100);
    wait_ticks(1);
    check("ring_timeout", int'(bus.AlarmHit), 0);
    check("ring_timeout_led", int'(bus.LEDAlarm), 0);
    bus.EN = 1'b0;
    pulse_m(59);
    pulse_m(1);
    check("adj_onto_alarm_min", int'(bus.Min), 30);
    check("adj_onto_alarm_hit", int'(bus.AlarmHit), 0);

    // Ack coinciding with a match loses; later ack and en=0 write clear
    do_reset();
    write_alarm(0, 1'b1, 0, 1);
    write_alarm(1, 1'b1, 0, 1);
    bus.EN = 1'b1;
    wait_ticks(59);
    check("pre_ack_sec", int'(bus.Sec), 59);
    wait_tick_seen();
    bus.AlarmAck = 1'b1;
    @(negedge CP50);
    bus.AlarmAck = 1'b0;
    check("ack_race_min", int'(bus.Min), 1);
    check("ack_race_hit", int'(bus.AlarmHit), 4'b0011);
    write_alarm(1, 1'b0, 0, 1);
    check("wr_dis_hit", int'(bus.AlarmHit), 4'b0001);
    bus.AlarmAck = 1'b1;
    @(negedge CP50);
    bus.AlarmAck = 1'b0;
    check("ack_hit", int'(bus.AlarmHit), 0);
    check("ack_led", int'(bus.LEDAlarm), 0);

    // Chime length and freeze under EN=0
    bus.EN = 1'b0;
    do_reset();
    pulse_m(59);
    bus.EN = 1'b1;
    wait_ticks(59);
    check("pre_chime_ledz", int'(bus.LEDZ), 0);
    wait_ticks(1);
    check_time("chime", 1, 0, 0);
    check("chime_on", int'(bus.LEDZ), 1);
    wait_ticks(2);
    bus.EN = 1'b0;
    repeat (20) @(negedge CP50);
    check("freeze_ledz", int'(bus.LEDZ), 1);
    check("freeze_sec", int'(bus.Sec), 2);
    check("freeze_tick", int'(bus.SecTick), 0);
    bus.EN = 1'b1;
    wait_ticks(2);
    check("chime_late", int'(bus.LEDZ), 1);
    wait_ticks(1);
    check("chime_off", int'(bus.LEDZ), 0);
    check("chime_off_sec", int'(bus.Sec), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_core_multi_alarm.md
Name: clock_core_multi_alarm

Overview:
- Parametrised time-of-day core for the board clock.
- Built from a configurable prescaler, an H:M:S counter chain, a 12/24-hour display mapping, hour/minute adjust, an N-entry alarm table with auto-timeout, and an hourly chime.
- Sits between the CP50 clock input and the 7-segment multiplexer/LED drivers; it produces binary time fields only, and BCD/segment encoding happens downstream.

Parameters:
- TICK_DIV, 50000000, CP50 cycles per second tick (small values for simulation).
- NUM_ALARMS, 4, number of alarm entries (1..16).
- RING_SECS, 30, seconds an alarm stays asserted before auto-clear.
- CHIME_SECS, 5, seconds LEDZ stays high after each hour boundary.

Ports:
- CP50 in 1: system clock. One clock; reset is synchronous and active-high.
- CR in 1: synchronous active-high clear.
- EN in 1: 1 = time runs; 0 = prescaler and time frozen.
- Ctrl24To12 in 1: 0 = 24 h display, 1 = 12 h display.
- AdjH in 1: debounced level; each rising edge adds one hour.
- AdjM in 1: debounced level; each rising edge adds one minute.
- AlarmWr in 1: write strobe for the alarm table.
- AlarmSel in 4: alarm entry index.
- AlarmEnIn in 1: enable bit to write.
- AlarmHIn in 5: alarm hour 0..23.
- AlarmMIn in 6: alarm minute 0..59.
- AlarmAck in 1: clears all active alarms.
- Hour out 5: 0..23.
- Min out 6: 0..59.
- Sec out 6: 0..59.
- DispHour out 5: mode-mapped hour.
- PM out 1: 1 when Hour >= 12.
- SecTick out 1: one-cycle pulse per second.
- AlarmHit out NUM_ALARMS: per-entry ringing flags.
- LEDAlarm out 1: OR of AlarmHit.
- LEDZ out 1: hourly chime.

Behaviour:
- Reset (CR=1 at a CP50 edge):
  - Hour, Min, Sec, prescaler, ring counter and chime counter all 0.
  - All alarm entries cleared: en=0, h=0, m=0.
  - AlarmHit=0, SecTick=0, LEDZ=0.
  - AdjH/AdjM edge-history registers set to 1, so a button held through reset does not fire.
  - CR overrides every other input.
- Prescaler:
  - Counts 0..TICK_DIV-1 while EN=1.
  - SecTick is registered: high for exactly one cycle, the cycle after the count reaches TICK_DIV-1 and wraps to 0.
  - EN=0 holds the count and forces SecTick=0.
- Tick carry chain (on SecTick):
  - Sec increments.
  - Sec 59->0 increments Min; Min 59->0 increments Hour; Hour 23->0.
  - 23:59:59 -> 00:00:00 in one tick.
- Adjust:
  - A rising edge is the input at 1 with its history at 0, registered one cycle.
  - AdjH: Hour+1 mod 24; Min and Sec untouched.
  - AdjM: Min+1 mod 60, no carry into Hour, and Sec cleared to 0.
  - Adjust works regardless of EN.
  - AdjH and AdjM edges in the same cycle are both applied.
  - If an adjust edge coincides with SecTick, the adjust is applied and that tick is discarded.
- Display mapping (combinational from Hour):
  - Ctrl24To12=0: DispHour=Hour.
  - Ctrl24To12=1: Hour 0 -> 12; 1..12 -> Hour; 13..23 -> Hour-12.
  - PM = (Hour>=12) in both modes.
- Alarm table:
  - AlarmWr=1 writes {AlarmEnIn, AlarmHIn, AlarmMIn} to entry AlarmSel at the next edge.
  - Writes are ignored if AlarmSel>=NUM_ALARMS, AlarmHIn>23, or AlarmMIn>59.
  - Matching is evaluated only on a tick that rolls Sec 59->0. An entry matches if it is enabled and equals the new Hour:Min; its AlarmHit bit is set the same cycle Hour/Min update.
  - Adjust landing on an alarm minute does not trigger it.
  - Writing an entry with en=0 clears its AlarmHit bit.
- Ring timeout:
  - The ring counter restarts at 0 whenever any hit is newly set.
  - It counts SecTicks while LEDAlarm=1; at RING_SECS it clears all AlarmHit bits.
  - AlarmAck clears all AlarmHit bits next cycle, but a new hit in the same cycle as AlarmAck wins and that bit is set.
- Chime:
  - On a tick rolling Min 59->0, LEDZ goes high and the chime counter loads CHIME_SECS.
  - Each SecTick decrements the counter; LEDZ drops when it reaches 0.
  - Adjust-induced hour changes do not chime.
  - EN=0 freezes the chime, ring counter and ring state.

Test Plan:
- Reset and rollover: TICK_DIV=4, CR pulse, EN=1. SecTick every 4 cycles; after 60 ticks Min=1, Sec=0. Preload 23:59:59 via adjust, one tick -> 00:00:00, PM=0.
- 12 h mapping: step Hour 0, 11, 12, 13, 23 with Ctrl24To12=1. DispHour/PM = 12/0, 11/0, 12/1, 1/1, 11/1.
- Adjust: hold AdjM 10 cycles -> Min +1 only, Sec=0. AdjH at Hour 23 -> 0, Min unchanged. AdjM edge on the SecTick cycle -> Sec=0, tick discarded. AdjH held through CR release -> no increment.
- Alarms: write entry 2 = {1,7,30}; run from 07:29:58. AlarmHit=4'b0100 and LEDAlarm=1 at the 07:30:00 tick. With RING_SECS=3, cleared after 3 ticks. AlarmSel=5 write has no effect. Entry with en=0 never hits.
- Ack race: AlarmAck asserted on the same cycle entry 0 matches -> AlarmHit[0]=1. Ack one cycle later -> all 0 next cycle.
- Chime and freeze: 00:59:59 plus one tick -> LEDZ=1 for CHIME_SECS ticks. EN=0 mid-chime -> LEDZ and Sec hold; EN=1 resumes the count.
